regbank_write_sequencer: RTL and testbench

// - Drives the register bank's control side: sel0/sel1 read selects, en one-hot write enables, ALUresult write data.
// - Accepts one instruction (rd, rs0, rs1) per valid/ready handshake and reads both source registers.
// - Hands the operands to the ALU, waits for alu_done, then writes the result to rd with a single one-cycle en pulse.
// - Single-issue: no new instruction is accepted until writeback or abort completes.

---
 rtl/regbank_write_sequencer_pkg.sv | 14 +
 rtl/regbank_write_sequencer_onehot_decoder.sv | 21 ++
 rtl/regbank_write_sequencer.sv | 116 +++++++++++
 tb/tb_regbank_write_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_write_sequencer_pkg.sv
// Shared constants and FSM state encoding for the register-bank write sequencer.
package regbank_write_sequencer_pkg;

    localparam int REG_SEL_W = 3;
    localparam int DATA_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/regbank_write_sequencer_onehot_decoder.sv
// Index to one-hot decoder; output is all zeros when enable is low.
module onehot_decoder #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 8
) (
    input  logic [IN_W-1:0]  idx,
    input  logic             enable,
    output logic [OUT_W-1:0] onehot
);

    // Set the single bit selected by idx when enabled.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (enable && (idx == IN_W'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regbank_write_sequencer.sv
// Single-issue sequencer: reads two source registers, hands them to the ALU,
// waits for alu_done (bounded by TIMEOUT) and writes the result back to rd
// with a one-cycle one-hot enable pulse.
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high. instr_ready is high only in IDLE; while it is low
// the upstream holds its fields and the sequencer ignores them.
module regbank_write_sequencer
    import regbank_write_sequencer_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int NREG    = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [REG_SEL_W-1:0] rd,
    input  logic [REG_SEL_W-1:0] rs0,
    input  logic [REG_SEL_W-1:0] rs1,
    input  logic [DATA_W-1:0]    Operand0,
    input  logic [DATA_W-1:0]    Operand1,
    output logic [REG_SEL_W-1:0] sel0,
    output logic [REG_SEL_W-1:0] sel1,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic                 alu_start,
    input  logic                 alu_done,
    input  logic [DATA_W-1:0]    alu_result,
    output logic [DATA_W-1:0]    ALUresult,
    output logic [NREG-1:0]      en,
    output logic                 err_timeout,
    output logic [15:0]          wr_count,
    output state_t               fsm_state
);

    state_t               state;
    logic [REG_SEL_W-1:0] rd_q;
    logic [7:0]           tmo_cnt;
    logic                 wr_fire;
    logic [NREG-1:0]      en_next;

    // A write is launched only from EXEC when the ALU reports completion.
    assign wr_fire     = (state == ST_EXEC) && alu_done;
    assign instr_ready = (state == ST_IDLE);
    assign fsm_state   = state;

    onehot_decoder #(
        .IN_W  (REG_SEL_W),
        .OUT_W (NREG)
    ) u_dec (
        .idx    (rd_q),
        .enable (wr_fire),
        .onehot (en_next)
    );

    // Sequencer FSM with registered outputs; en is the registered decoder
    // output, so it is nonzero only in the WRITE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            rd_q        <= '0;
            sel0        <= '0;
            sel1        <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_start   <= 1'b0;
            ALUresult   <= '0;
            en          <= '0;
            err_timeout <= 1'b0;
            wr_count    <= '0;
            tmo_cnt     <= '0;
        end else begin
            alu_start   <= 1'b0;
            err_timeout <= 1'b0;
            en          <= en_next;
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        rd_q  <= rd;
                        sel0  <= rs0;
                        sel1  <= rs1;
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    // Bank has been driven from the registered sels for a full cycle.
                    alu_a     <= Operand0;
                    alu_b     <= Operand1;
                    alu_start <= 1'b1;
                    tmo_cnt   <= '0;
                    state     <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (alu_done) begin
                        ALUresult <= alu_result;
                        state     <= ST_WRITE;
                    end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
                        // This is the TIMEOUT-th EXEC cycle without completion.
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ST_WRITE: begin
                    wr_count <= wr_count + 16'd1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_write_sequencer.sv
// Directed bench for regbank_write_sequencer with a behavioural register bank.
module tb_regbank_write_sequencer;
    import regbank_write_sequencer_pkg::*;

    localparam int DW = 16;
    localparam int NR = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          instr_valid;
    logic          instr_ready;
    logic [2:0]    rd, rs0, rs1;
    logic [DW-1:0] Operand0, Operand1;
    logic [2:0]    sel0, sel1;
    logic [DW-1:0] alu_a, alu_b;
    logic          alu_start;
    logic          alu_done;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] ALUresult;
    logic [NR-1:0] en;
    logic          err_timeout;
    logic [15:0]   wr_count;
    state_t        fsm_state;

    regbank_write_sequencer #(.DATA_W(DW), .NREG(NR), .TIMEOUT(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .rd          (rd),
        .rs0         (rs0),
        .rs1         (rs1),
        .Operand0    (Operand0),
        .Operand1    (Operand1),
        .sel0        (sel0),
        .sel1        (sel1),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_start   (alu_start),
        .alu_done    (alu_done),
        .alu_result  (alu_result),
        .ALUresult   (ALUresult),
        .en          (en),
        .err_timeout (err_timeout),
        .wr_count    (wr_count),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    // Behavioural register bank: combinational reads, write on en pulse.
    logic [DW-1:0] bank [NR];
    assign Operand0 = bank[sel0];
    assign Operand1 = bank[sel1];
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (en[i]) bank[i] <= ALUresult;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int exp_wr = 0;

    typedef struct {
        logic [2:0]  rd;
        logic [2:0]  rs0;
        logic [2:0]  rs1;
        logic [15:0] v0;
        logic [15:0] v1;
        logic [15:0] result;
        int          delay;
        bit          timeout;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!instr_ready && n < 40) begin
            step();
            n++;
        end
        if (!instr_ready) check("ready_wait_expired", 32'(instr_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] exp_en;
        exp_en = 8'd1 << v.rd;
        wait_ready();
        bank[v.rs0] <= v.v0;
        bank[v.rs1] <= v.v1;
        instr_valid = 1'b1;
        rd  = v.rd;
        rs0 = v.rs0;
        rs1 = v.rs1;
        step();
        instr_valid = 1'b0;
        check("read_state", 32'(fsm_state), 32'(ST_READ));
        check("ready_low", 32'(instr_ready), 32'd0);
        check("sel0", 32'(sel0), 32'(v.rs0));
        check("sel1", 32'(sel1), 32'(v.rs1));
        step();
        check("alu_start", 32'(alu_start), 32'd1);
        check("alu_a", 32'(alu_a), 32'(v.v0));
        check("alu_b", 32'(alu_b), 32'(v.v1));
        if (v.timeout) begin
            alu_done = 1'b0;
            for (int i = 0; i < 14; i++) begin
                step();
                check("tmo_wait_en", 32'(en), 32'd0);
                check("tmo_wait_err", 32'(err_timeout), 32'd0);
                check("tmo_wait_start", 32'(alu_start), 32'd0);
            end
            step();
            check("tmo_err", 32'(err_timeout), 32'd1);
            check("tmo_en", 32'(en), 32'd0);
            check("tmo_ready", 32'(instr_ready), 32'd1);
            check("tmo_wr_count", 32'(wr_count), 32'(exp_wr));
            step();
            check("tmo_err_pulse", 32'(err_timeout), 32'd0);
            check("tmo_en_after", 32'(en), 32'd0);
        end else begin
            alu_done = 1'b0;
            for (int i = 0; i < v.delay; i++) begin
                if (i > 0 || 1'b1) step();
                check("exec_en_zero", 32'(en), 32'd0);
            end
            if (v.delay == 0) begin
                alu_done   = 1'b1;
                alu_result = v.result;
            end else begin
                alu_done   = 1'b1;
                alu_result = v.result;
            end
            step();
            alu_done = 1'b0;
            check("write_state", 32'(fsm_state), 32'(ST_WRITE));
            check("write_en", 32'(en), 32'(exp_en));
            check("ALUresult", 32'(ALUresult), 32'(v.result));
            step();
            exp_wr++;
            check("en_cleared", 32'(en), 32'd0);
            check("wr_count", 32'(wr_count), 32'(exp_wr));
            check("ready_back", 32'(instr_ready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] b2b_rd [4];
        int last_acc;
        logic [7:0] e;

        vecs[0] = '{3'd5, 3'd1, 3'd2, 16'h0003, 16'h0004, 16'h0007, 0, 1'b0};
        vecs[1] = '{3'd3, 3'd3, 3'd3, 16'h00F0, 16'h00F0, 16'h01E0, 0, 1'b0};
        vecs[2] = '{3'd0, 3'd4, 3'd5, 16'hFFFF, 16'h0001, 16'hBEEF, 14, 1'b0};
        vecs[3] = '{3'd7, 3'd6, 3'd1, 16'h0A0A, 16'h5050, 16'h1234, 3, 1'b0};
        vecs[4] = '{3'd6, 3'd0, 3'd7, 16'h1111, 16'h2222, 16'h9999, 15, 1'b1};
        b2b_rd[0] = 3'd1;
        b2b_rd[1] = 3'd2;
        b2b_rd[2] = 3'd4;
        b2b_rd[3] = 3'd6;

        reset       = 1'b1;
        instr_valid = 1'b0;
        rd          = '0;
        rs0         = '0;
        rs1         = '0;
        alu_done    = 1'b0;
        alu_result  = '0;
        for (int i = 0; i < NR; i++) bank[i] <= '0;

        // Reset behaviour.
        repeat (2) step();
        check("rst_en", 32'(en), 32'd0);
        check("rst_sel0", 32'(sel0), 32'd0);
        check("rst_sel1", 32'(sel1), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_start", 32'(alu_start), 32'd0);
        check("rst_ALUresult", 32'(ALUresult), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        reset = 1'b0;
        step();
        check("idle_ready", 32'(instr_ready), 32'd1);
        check("idle_state", 32'(fsm_state), 32'(ST_IDLE));

        // Table-driven instructions.
        for (int k = 0; k < 5; k++) run_vec(vecs[k]);

        // alu_done outside EXEC is ignored; ALUresult holds its last value.
        alu_done   = 1'b1;
        alu_result = 16'hDEAD;
        step();
        step();
        alu_done = 1'b0;
        check("idle_done_en", 32'(en), 32'd0);
        check("idle_done_state", 32'(fsm_state), 32'(ST_IDLE));
        check("ALUresult_hold", 32'(ALUresult), 32'h1234);
        check("idle_wr_count", 32'(wr_count), 32'(exp_wr));

        // Reset while in EXEC: no write, counters cleared.
        wait_ready();
        instr_valid = 1'b1;
        rd  = 3'd2;
        rs0 = 3'd1;
        rs1 = 3'd1;
        step();
        instr_valid = 1'b0;
        step();
        check("pre_rst_exec", 32'(fsm_state), 32'(ST_EXEC));
        reset = 1'b1;
        step();
        reset      = 1'b0;
        alu_done   = 1'b1;
        alu_result = 16'hFFFF;
        exp_wr     = 0;
        check("rst_exec_state", 32'(fsm_state), 32'(ST_IDLE));
        check("rst_exec_en", 32'(en), 32'd0);
        check("rst_exec_wr_count", 32'(wr_count), 32'd0);
        step();
        alu_done = 1'b0;
        check("rst_exec_en2", 32'(en), 32'd0);
        check("rst_exec_ready", 32'(instr_ready), 32'd1);
        step();
        check("rst_exec_en3", 32'(en), 32'd0);

        // Back-to-back: instr_valid held high across four instructions.
        for (int i = 0; i < NR; i++) bank[i] <= 16'(i * 16'h0011);
        instr_valid = 1'b1;
        last_acc = 0;
        for (int k = 0; k < 4; k++) begin
            rd  = b2b_rd[k];
            rs0 = 3'(k);
            rs1 = 3'(k + 1);
            wait_ready();
            if (k > 0) check("accept_spacing", 32'(cyc - last_acc), 32'd4);
            last_acc = cyc;
            step();
            check("b2b_read", 32'(fsm_state), 32'(ST_READ));
            step();
            check("b2b_start", 32'(alu_start), 32'd1);
            alu_done   = 1'b1;
            alu_result = 16'h0100 + 16'(k);
            step();
            alu_done = 1'b0;
            e = 8'd1 << b2b_rd[k];
            check("b2b_en", 32'(en), 32'(e));
            step();
            exp_wr++;
            check("b2b_wr_count", 32'(wr_count), 32'(exp_wr));
        end
        instr_valid = 1'b0;
        step();
        check("final_wr_count", 32'(wr_count), 32'd4);
        check("final_en", 32'(en), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
